// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and single-outstanding instruction fetch with decode hand-off buffer
module pc_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic                  branch_taken,
  output logic [ADDR_WIDTH-1:0] pc_address,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic [31:0]           fetch_count,
  output logic [31:0]           branch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;

  assign pc_address    = pc;
  assign imem_req_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      fetch_count    <= 32'd0;
      branch_count   <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          // Out of reset the request is raised one edge late; after an
          // acceptance in HOLD it is already raised, keeping the 3-cycle loop.
          if (!imem_req_valid) begin
            imem_req_valid <= 1'b1;
          end else if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc             <= next_pc;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
            if (branch_taken) begin
              branch_count <= branch_count + 32'd1;
            end
            state          <= S_REQ;
          end
        end
        default: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential stage directly upstream of the branch-control stage.
- Holds the architectural PC register and drives pc_address to the branch-control stage.
- Fetches the instruction at the PC from instruction memory over a request/response handshake, then presents it to decode.
- On each decode acceptance, loads the next_pc and branch_taken produced by the branch-control stage.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width; PC is a word address and increments by 1.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- next_pc  input  ADDR_WIDTH  next PC from branch control.
- branch_taken  input  1  branch-taken flag from branch control.
- pc_address  output  ADDR_WIDTH  current PC register, sent to branch control.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  ADDR_WIDTH  fetch address.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  DATA_WIDTH  fetched instruction.
- instr_valid  output  1  instruction buffer holds a valid instruction.
- instr  output  DATA_WIDTH  buffered instruction.
- instr_pc  output  ADDR_WIDTH  PC of buffered instruction.
- instr_ready  input  1  decode/execute consumes the instruction this cycle.
- fetch_count  output  32  instructions retired, i.e. accepted by decode.
- branch_count  output  32  accepted instructions with branch_taken=1.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - pc=RESET_PC, state=REQ.
  - imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
  - fetch_count=0, branch_count=0.
- The first request is asserted on the first clock edge after rst_n is high.
- State REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - imem_req_addr stays stable until imem_req_ready=1 at a rising edge; then go to WAIT.
- State WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1 at an edge: instr<=imem_rsp_data, instr_pc<=pc, instr_valid<=1, go to HOLD.
- State HOLD:
  - instr_valid=1; instr and instr_pc are stable.
  - On instr_ready=1 at an edge:
    - pc<=next_pc, instr_valid<=0.
    - fetch_count+=1; branch_count+=1 if branch_taken=1.
    - Go to REQ.
- Minimum per-instruction latency: 3 cycles (REQ accept, response, accept).
- pc_address always equals the pc register, so the branch-control stage sees a stable PC for the whole HOLD interval.
- next_pc is loaded verbatim; 0xFFFFFFFF+1 wraps to 0 in the upstream adder, and the PC register performs no correction.
- Ignored inputs:
  - imem_rsp_valid outside WAIT is ignored; there is no buffering of stray responses.
  - instr_ready outside HOLD is ignored.
  - imem_req_ready outside REQ is ignored.
  - next_pc and branch_taken are sampled only on a HOLD acceptance edge.
- Counters wrap modulo 2^32 with no saturation.
- Reset mid-WAIT or mid-HOLD discards any outstanding request or instruction. After rst_n rises, the fetch restarts from RESET_PC.
- Simultaneous imem_req_ready and imem_rsp_valid in REQ: only the REQ→WAIT transition occurs. The response is not captured, because the memory must respond no earlier than the cycle after acceptance.

Test Plan:
- Reset release, imem ready always, 1-cycle response, instr_ready=1, next_pc=pc+1, branch_taken=0:
  - imem_req_addr sequence is 0,1,2,3 with one instruction per 3 cycles.
  - fetch_count=4 after 4 acceptances.
- Branch redirect: in HOLD at pc=5, drive next_pc=0x40 and branch_taken=1 with instr_ready=1:
  - Next imem_req_addr=0x40, branch_count=1, instr_pc of the next instruction=0x40.
- Backpressure:
  - imem_req_ready low for 4 cycles in REQ → imem_req_addr held constant and state stays REQ.
  - instr_ready low for 5 cycles in HOLD → instr and instr_pc stable, pc_address unchanged, no new request.
- Stray response: imem_rsp_valid=1 with data 0xDEADBEEF while in REQ → ignored, instr_valid stays 0, later response 0x00500093 is captured.
- Asynchronous reset asserted mid-WAIT (between clock edges) → outputs clear immediately, with no clock edge needed. After release, the first imem_req_addr=RESET_PC and fetch_count=0.
- Wrap: next_pc=0xFFFFFFFF then next_pc=0 → fetch addresses are 0xFFFFFFFF then 0x00000000.
